// File: rtl/key_state_decoder.sv
// PS/2 set-2 scan byte decoder: handles make, break (F0) and extended (E0) prefixes.
// Produces the last plain make code and a held/released bitmap for the 16 game keys.
module key_state_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_300_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [6:0]  keyCode,
  output logic [15:0] released,
  output logic        key_event
);

  // state   | meaning
  // IDLE    | no prefix pending; next byte is a plain make or a prefix
  // BRK     | F0 seen; next non-prefix byte is a plain break
  // EXT     | E0 seen; next non-prefix byte is an extended make
  // EXT_BRK | E0 F0 seen; next non-prefix byte is an extended break
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [6:0]       key_code_q, key_code_d;
  logic [15:0]      released_q, released_d;
  logic             key_event_q, key_event_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic             is_prefix;
  logic             tmo_expired;
  logic [15:0]      plain_mask;
  logic [15:0]      ext_mask;

  // One-hot bitmap position of a game key, matched with its full prefix context.
  function automatic logic [15:0] game_key_mask(input logic ext, input logic [7:0] code);
    logic [15:0] m;
    m = '0;
    if (ext) begin
      case (code)
        8'h75:   m[0] = 1'b1;
        8'h72:   m[1] = 1'b1;
        8'h6B:   m[2] = 1'b1;
        8'h74:   m[3] = 1'b1;
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h29:   m[4]  = 1'b1;
        8'h1D:   m[5]  = 1'b1;
        8'h1C:   m[6]  = 1'b1;
        8'h1B:   m[7]  = 1'b1;
        8'h23:   m[8]  = 1'b1;
        8'h5A:   m[9]  = 1'b1;
        8'h76:   m[10] = 1'b1;
        8'h4D:   m[11] = 1'b1;
        8'h2D:   m[12] = 1'b1;
        8'h15:   m[13] = 1'b1;
        8'h24:   m[14] = 1'b1;
        8'h2B:   m[15] = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  assign is_prefix   = (rx_data == BYTE_EXT) || (rx_data == BYTE_BRK);
  assign tmo_expired = (state_q != IDLE) && (tmo_cnt_q == TMO_LAST);
  assign plain_mask  = game_key_mask(1'b0, rx_data);
  assign ext_mask    = game_key_mask(1'b1, rx_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      key_code_q  <= '0;
      released_q  <= 16'hFFFF;
      key_event_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      released_q  <= released_d;
      key_event_q <= key_event_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    released_d  = released_q;
    key_event_d = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;

    if (rx_valid) begin
      // A byte arriving on the expiry cycle is still decoded in the pending state.
      tmo_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == BYTE_EXT) begin
            state_d = EXT;
          end else if (rx_data == BYTE_BRK) begin
            state_d = BRK;
          end else begin
            key_event_d = 1'b1;
            released_d  = released_q & ~plain_mask;
            if (!rx_data[7]) begin
              key_code_d = rx_data[6:0];
            end
          end
        end
        EXT: begin
          if (rx_data == BYTE_BRK) begin
            state_d = EXT_BRK;
          end else if (rx_data != BYTE_EXT) begin
            state_d     = IDLE;
            key_event_d = 1'b1;
            released_d  = released_q & ~ext_mask;
          end
        end
        BRK: begin
          if (!is_prefix) begin
            state_d     = IDLE;
            key_event_d = 1'b1;
            released_d  = released_q | plain_mask;
            if (!rx_data[7] && (rx_data[6:0] == key_code_q)) begin
              key_code_d = '0;
            end
          end
        end
        EXT_BRK: begin
          if (!is_prefix) begin
            state_d     = IDLE;
            key_event_d = 1'b1;
            released_d  = released_q | ext_mask;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (tmo_expired) begin
      state_d   = IDLE;
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + CNT_ONE;
    end
  end

  assign keyCode   = key_code_q;
  assign released  = released_q;
  assign key_event = key_event_q;

endmodule

// File: tb/tb_key_state_decoder.sv
// Directed-vector bench for key_state_decoder with a short prefix timeout.
`timescale 1ns/1ps
module tb_key_state_decoder;

  localparam int unsigned T = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [6:0]  keyCode;
  logic [15:0] released;
  logic        key_event;

  int n_checks = 0;
  int n_errors = 0;
  int ev_cnt   = 0;
  int ev_base;

  key_state_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .keyCode   (keyCode),
    .released  (released),
    .key_event (key_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (key_event) ev_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic outs(input string tag, input logic [6:0] kc, input logic [15:0] rel);
    check({tag, ".kc"},  {25'd0, keyCode}, {25'd0, kc});
    check({tag, ".rel"}, {16'd0, released}, {16'd0, rel});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    outs("reset", 7'h00, 16'hFFFF);
    check("reset.ev", {31'd0, key_event}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    send(8'h32);
    outs("make32", 7'h32, 16'hFFFF);
    check("make32.ev", {31'd0, key_event}, 32'd1);
    @(negedge clk);
    check("make32.ev_off", {31'd0, key_event}, 32'd0);

    send(8'hF0);
    check("f0.ev", {31'd0, key_event}, 32'd0);
    check("f0.kc", {25'd0, keyCode}, 32'h32);
    send(8'h32);
    outs("brk32", 7'h00, 16'hFFFF);
    check("brk32.ev", {31'd0, key_event}, 32'd1);
    @(negedge clk);

    #1 ev_base = ev_cnt;
    send(8'hE0);
    send(8'h6B);
    outs("e0_6b", 7'h00, 16'hFFFB);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    outs("e0f0_6b", 7'h00, 16'hFFFF);
    repeat (2) @(negedge clk);
    #1 check("ext.ev_count", ev_cnt - ev_base, 32'd2);
    @(negedge clk);

    send(8'h1D);
    send(8'h1C);
    outs("wa", 7'h1C, 16'hFF9F);
    send(8'hF0);
    send(8'h1D);
    outs("brk_w", 7'h1C, 16'hFFBF);
    send(8'hF0);
    send(8'h1C);
    outs("brk_a", 7'h00, 16'hFFFF);

    // Prefix dropped after T silent cycles: 29 is a plain space make.
    #1 ev_base = ev_cnt;
    @(negedge clk);
    send(8'hE0);
    repeat (T) @(negedge clk);
    #1 check("tmo.no_ev", ev_cnt - ev_base, 32'd0);
    send(8'h29);
    outs("tmo_plain", 7'h29, 16'hFFEF);
    send(8'hF0);
    send(8'h29);
    outs("brk_space", 7'h00, 16'hFFFF);

    // Byte on the expiry cycle wins: extended 29, unmapped.
    send(8'hE0);
    repeat (T - 1) @(negedge clk);
    send(8'h29);
    outs("tmo_edge", 7'h00, 16'hFFFF);
    check("tmo_edge.ev", {31'd0, key_event}, 32'd1);

    send(8'h29);
    outs("space2", 7'h29, 16'hFFEF);
    send(8'h29);
    outs("typematic", 7'h29, 16'hFFEF);
    send(8'h75);
    outs("plain75", 7'h75, 16'hFFEF);
    send(8'h83);
    outs("hi_make", 7'h75, 16'hFFEF);
    check("hi_make.ev", {31'd0, key_event}, 32'd1);
    send(8'hF0);
    send(8'hE0);
    send(8'h29);
    outs("brk_ignore_e0", 7'h75, 16'hFFFF);

    send(8'h29);
    send(8'hF0);
    rst = 1'b0;
    #1 outs("midreset", 7'h00, 16'hFFFF);
    check("midreset.ev", {31'd0, key_event}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(8'h29);
    outs("after_rst", 7'h29, 16'hFFEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_state_decoder.md
Name: key_state_decoder

Overview:
- Upstream stage of the player movement block. Consumes PS/2 set-2 scan bytes from the PS/2 receiver and produces the keyCode / released pair that movement reads.
- Decodes make, break (F0) and extended (E0) prefixes.
- Tracks the last pressed plain key and a held/released bitmap for the 16 game keys.
- Drops half-received prefix sequences after a timeout.

Parameters:
- TIMEOUT_CYCLES, 1_300_000, clk cycles of rx_valid silence after which a pending prefix is discarded (≈20 ms at 65 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active low
- rx_data  in  8  scan byte from PS/2 receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid while high
- keyCode  out  7  last plain make code (rx_data[6:0]); 0 = none
- released  out  16  per-game-key flag; 1 = key not held, 0 = held
- key_event  out  1  one-cycle pulse per completed make or break frame

Behaviour:
- Reset (rst low, async): keyCode = 0, released = 16'hFFFF, key_event = 0, state = IDLE, timeout counter = 0.
- All outputs are registered. On the edge that samples the final byte of a frame, the new values appear after that edge; latency is 1 clk.
- Bytes are accepted only on cycles where rx_valid = 1.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
- Transitions from IDLE:
  - E0 -> EXT
  - F0 -> BRK
  - any other byte = plain make; stay in IDLE.
- Transitions from EXT:
  - F0 -> EXT_BRK
  - E0 -> stay in EXT
  - any other byte = extended make -> IDLE
- Transitions from BRK:
  - F0 or E0 -> stay in BRK; the byte is ignored.
  - any other byte = plain break -> IDLE
- Transitions from EXT_BRK:
  - F0 or E0 -> stay in EXT_BRK; the byte is ignored.
  - any other byte = extended break -> IDLE
- Plain make, byte < 8'h80: keyCode <= byte[6:0].
- Plain make, byte ≥ 8'h80: keyCode is unchanged.
- Plain break: if byte[6:0] == keyCode and byte < 8'h80, then keyCode <= 0; otherwise keyCode is unchanged.
- Extended make/break never change keyCode.
- Game-key map (bit : code):
  - 0 : E0 75 up
  - 1 : E0 72 down
  - 2 : E0 6B left
  - 3 : E0 74 right
  - 4 : 29 space
  - 5 : 1D W
  - 6 : 1C A
  - 7 : 1B S
  - 8 : 23 D
  - 9 : 5A enter
  - 10 : 76 esc
  - 11 : 4D P
  - 12 : 2D R
  - 13 : 15 Q
  - 14 : 24 E
  - 15 : 2B F
- Map matching uses the full prefix context: a plain 75 does not hit bit 0, and E0 29 does not hit bit 4.
- A make of a mapped key clears its bit; a break of a mapped key sets its bit. Unmapped codes leave released unchanged.
- key_event = 1 for exactly one cycle after each completed frame, including typematic repeats and unmapped codes. It is 0 otherwise.
- Typematic repeat (repeat make of a held key) reloads keyCode with the same value; released is unchanged.
- Timeout: the counter increments each cycle while state ≠ IDLE and rx_valid = 0. The counter is cleared on every rx_valid and whenever state = IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1: state <= IDLE, no output change, no key_event.
  - If rx_valid coincides with expiry, the byte wins and is decoded in the current state.
- Reset mid-frame: the pending prefix is lost and all outputs return to their reset values.

Test Plan:
- Reset, then byte 32 -> keyCode = 7'h32, released = FFFF, one key_event pulse one cycle later.
- After 32 is held, bytes F0 32 -> keyCode = 0, released = FFFF, one key_event; no pulse after the F0 byte alone.
- Bytes E0 6B -> released = FFFB, keyCode unchanged. Then E0 F0 6B -> released = FFFF. Exactly 2 key_event pulses in total.
- Byte 1D, then 1C -> released = FF9F, keyCode = 1C. Then F0 1D -> released = FFBF, keyCode stays 1C.
- Bytes E0 followed by TIMEOUT_CYCLES idle cycles, then 29 -> treated as plain space: released = FFEF, keyCode = 29. Repeat the case with 29 arriving on the expiry cycle -> extended 29: released = FFFF, keyCode unchanged.
- Assert rst low between F0 and 29 while 29 is held -> outputs = 0 / FFFF immediately. A following lone 29 is a make: keyCode = 29.
